// File: rtl/fifo_in_store.sv
// ============================================================================
//  Module   : fifo_in_store
//  Purpose  : Eight-entry FIFO storage stage. It registers the pointers and
//             count proposed by the address-calculation stage, owns the
//             memory array, and returns the status flags and handshake pulses.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_in_store #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            state,
  input  logic                  we,
  input  logic                  re,
  input  logic [2:0]            next_head,
  input  logic [2:0]            next_tail,
  input  logic [3:0]            next_data_count,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [2:0]            head,
  output logic [2:0]            tail,
  output logic [3:0]            data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_WRITE    = 3'd1;
  localparam logic [2:0] c_ST_READ     = 3'd2;
  localparam logic [2:0] c_ST_WR_ERROR = 3'd3;
  localparam logic [2:0] c_ST_RD_ERROR = 3'd4;
  localparam logic [3:0] c_DEPTH       = 4'd8;
  localparam int         c_ENTRIES     = 8;

  logic [DATA_WIDTH-1:0] r_mem [c_ENTRIES];
  logic [DATA_WIDTH-1:0] r_dout;
  logic [2:0]            r_head;
  logic [2:0]            r_tail;
  logic [3:0]            r_data_count;
  logic                  r_wr_ack;
  logic                  r_wr_err;
  logic                  r_rd_ack;
  logic                  r_rd_err;

  logic w_full;
  logic w_empty;
  logic w_bad_cmd;
  logic w_guard;
  logic w_idle_like;
  logic w_wr_legal;
  logic w_rd_legal;
  logic w_load_ptrs;

  assign w_full  = (r_data_count == c_DEPTH);
  assign w_empty = (r_data_count == 4'd0);

  // Contradictory enables or an undefined state code freeze everything and
  // silence all handshakes, taking priority over the error-state reporting.
  assign w_bad_cmd = (we & re) | (state > c_ST_RD_ERROR);

  // Overflow/underflow attempts and out-of-range proposed counts keep the
  // registered pointers; the address stage must not be trusted there.
  assign w_guard = (we & w_full) | (re & w_empty) | (next_data_count > c_DEPTH);

  assign w_idle_like = (state == c_ST_IDLE) | (state == c_ST_WR_ERROR) |
                       (state == c_ST_RD_ERROR);

  assign w_wr_legal  = ~w_bad_cmd & ~w_guard & (state == c_ST_WRITE) & we;
  assign w_rd_legal  = ~w_bad_cmd & ~w_guard & (state == c_ST_READ)  & re;
  assign w_load_ptrs = w_wr_legal | w_rd_legal | (~w_bad_cmd & ~w_guard & w_idle_like);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_ENTRIES; i++) begin
        r_mem[i] <= '0;
      end
      r_dout       <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_data_count <= '0;
      r_wr_ack     <= 1'b0;
      r_wr_err     <= 1'b0;
      r_rd_ack     <= 1'b0;
      r_rd_err     <= 1'b0;
    end else begin
      if (w_wr_legal) begin
        r_mem[r_tail] <= din;
      end
      if (w_rd_legal) begin
        r_dout <= r_mem[r_head];
      end
      if (w_load_ptrs) begin
        r_head       <= next_head;
        r_tail       <= next_tail;
        r_data_count <= next_data_count;
      end
      r_wr_ack <= w_wr_legal;
      r_rd_ack <= w_rd_legal;
      r_wr_err <= ~w_bad_cmd & ((state == c_ST_WR_ERROR) | (we & w_full));
      r_rd_err <= ~w_bad_cmd & ((state == c_ST_RD_ERROR) | (re & w_empty));
    end
  end

  assign dout       = r_dout;
  assign head       = r_head;
  assign tail       = r_tail;
  assign data_count = r_data_count;
  assign full       = w_full;
  assign empty      = w_empty;
  assign wr_ack     = r_wr_ack;
  assign wr_err     = r_wr_err;
  assign rd_ack     = r_rd_ack;
  assign rd_err     = r_rd_err;

endmodule

`default_nettype wire

// File: tb/tb_fifo_in_store.sv
// ============================================================================
//  Module   : tb_fifo_in_store
//  Purpose  : Self-checking bench for fifo_in_store with a read-data scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_in_store;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    state;
  logic          we;
  logic          re;
  logic [2:0]    next_head;
  logic [2:0]    next_tail;
  logic [3:0]    next_data_count;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic [2:0]    head;
  logic [2:0]    tail;
  logic [3:0]    data_count;
  logic          full;
  logic          empty;
  logic          wr_ack;
  logic          wr_err;
  logic          rd_ack;
  logic          rd_err;

  int checks = 0;
  int errors = 0;

  // Reference model of the storage stage
  logic [DW-1:0] m_mem [8];
  logic [2:0]    m_head;
  logic [2:0]    m_tail;
  logic [3:0]    m_count;
  logic [DW-1:0] m_dout;
  logic [DW-1:0] exp_q [$];

  fifo_in_store #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .state(state), .we(we), .re(re),
    .next_head(next_head), .next_tail(next_tail), .next_data_count(next_data_count),
    .din(din), .dout(dout), .head(head), .tail(tail), .data_count(data_count),
    .full(full), .empty(empty), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_ack(rd_ack), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    state = 3'd0; we = 1'b0; re = 1'b0;
    next_head = m_head; next_tail = m_tail; next_data_count = m_count;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_head = '0; m_tail = '0; m_count = '0; m_dout = '0;
  endtask

  task automatic test_reset();
    logic [20:0] act;
    reset = 1'b1; state = 3'd0; we = 1'b0; re = 1'b0;
    next_head = 3'd0; next_tail = 3'd0; next_data_count = 4'd0; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    act = {head, tail, data_count, full, empty, wr_ack, wr_err, rd_ack, rd_err, 6'd0};
    checks++;
    if (act !== {3'd0, 3'd0, 4'd0, 1'b0, 1'b1, 4'b0000, 6'd0}) begin
      errors++; $display("FAIL reset_state actual=%h required=%h", act, {3'd0, 3'd0, 4'd0, 1'b0, 1'b1, 4'b0000, 6'd0});
    end
    checks++;
    if (dout !== '0) begin errors++; $display("FAIL reset_dout actual=%h required=0", dout); end
    reset = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      state = 3'd1; we = 1'b1; re = 1'b0; din = 32'hA0 + i;
      next_head = m_head; next_tail = m_tail + 3'd1; next_data_count = m_count + 4'd1;
      m_mem[m_tail] = din; m_tail = m_tail + 3'd1; m_count = m_count + 4'd1;
      cyc();
      checks++;
      if ({tail, data_count, wr_ack, rd_ack} !== {m_tail, m_count, 2'b10}) begin
        errors++; $display("FAIL fill_%0d actual=%h required=%h", i, {tail, data_count, wr_ack, rd_ack}, {m_tail, m_count, 2'b10});
      end
    end
    checks++;
    if ({full, empty, tail, data_count} !== {2'b10, 3'd0, 4'd8}) begin
      errors++; $display("FAIL fill_full actual=%h required=%h", {full, empty, tail, data_count}, {2'b10, 3'd0, 4'd8});
    end
    go_idle(); cyc();
    checks++;
    if (wr_ack !== 1'b0) begin errors++; $display("FAIL fill_ack_pulse actual=%b required=0", wr_ack); end
  endtask

  task automatic test_wr_full();
    state = 3'd1; we = 1'b1; re = 1'b0; din = 32'hDEAD_BEEF;
    next_head = m_head; next_tail = 3'd1; next_data_count = 4'd9;
    cyc();
    checks++;
    if ({tail, data_count, wr_ack, wr_err} !== {3'd0, 4'd8, 2'b01}) begin
      errors++; $display("FAIL wr_full actual=%h required=%h", {tail, data_count, wr_ack, wr_err}, {3'd0, 4'd8, 2'b01});
    end
    go_idle(); cyc();
    checks++;
    if (wr_err !== 1'b0) begin errors++; $display("FAIL wr_full_pulse actual=%b required=0", wr_err); end
  endtask

  task automatic test_drain();
    logic [DW-1:0] exp;
    for (int i = 0; i < 8; i++) begin
      state = 3'd2; we = 1'b0; re = 1'b1;
      next_head = m_head + 3'd1; next_tail = m_tail; next_data_count = m_count - 4'd1;
      exp_q.push_back(m_mem[m_head]);
      m_head = m_head + 3'd1; m_count = m_count - 4'd1;
      cyc();
      exp = exp_q.pop_front();
      m_dout = exp;
      checks++;
      if ({dout, rd_ack, head} !== {exp, 1'b1, m_head}) begin
        errors++; $display("FAIL drain_%0d actual=%h required=%h", i, {dout, rd_ack, head}, {exp, 1'b1, m_head});
      end
    end
    checks++;
    if ({empty, full, head} !== {2'b10, 3'd0}) begin
      errors++; $display("FAIL drain_empty actual=%h required=%h", {empty, full, head}, {2'b10, 3'd0});
    end
  endtask

  task automatic test_rd_empty();
    state = 3'd2; we = 1'b0; re = 1'b1;
    next_head = 3'd3; next_tail = m_tail; next_data_count = 4'd0;
    cyc();
    checks++;
    if ({dout, head, rd_ack, rd_err} !== {m_dout, m_head, 2'b01}) begin
      errors++; $display("FAIL rd_empty actual=%h required=%h", {dout, head, rd_ack, rd_err}, {m_dout, m_head, 2'b01});
    end
    go_idle(); cyc();
    checks++;
    if (rd_err !== 1'b0) begin errors++; $display("FAIL rd_empty_pulse actual=%b required=0", rd_err); end
  endtask

  task automatic test_illegal();
    // WR_ERROR with both enables: the error report must be suppressed too
    state = 3'd3; we = 1'b1; re = 1'b1; din = 32'h1234;
    next_head = 3'd5; next_tail = 3'd6; next_data_count = 4'd2;
    cyc();
    checks++;
    if ({head, tail, data_count, wr_ack, wr_err, rd_ack, rd_err, dout} !== {m_head, m_tail, m_count, 4'b0000, m_dout}) begin
      errors++; $display("FAIL illegal_we_re actual=%h required=%h", {head, tail, data_count, wr_ack, wr_err, rd_ack, rd_err, dout}, {m_head, m_tail, m_count, 4'b0000, m_dout});
    end
    state = 3'd6; we = 1'b0; re = 1'b1;
    cyc();
    checks++;
    if ({head, tail, data_count, wr_ack, wr_err, rd_ack, rd_err, dout} !== {m_head, m_tail, m_count, 4'b0000, m_dout}) begin
      errors++; $display("FAIL illegal_state6 actual=%h required=%h", {head, tail, data_count, wr_ack, wr_err, rd_ack, rd_err, dout}, {m_head, m_tail, m_count, 4'b0000, m_dout});
    end
  endtask

  task automatic test_passthrough();
    state = 3'd0; we = 1'b0; re = 1'b0;
    next_head = 3'd2; next_tail = 3'd5; next_data_count = 4'd3;
    m_head = 3'd2; m_tail = 3'd5; m_count = 4'd3;
    cyc();
    checks++;
    if ({head, tail, data_count, wr_err} !== {m_head, m_tail, m_count, 1'b0}) begin
      errors++; $display("FAIL pass_idle actual=%h required=%h", {head, tail, data_count, wr_err}, {m_head, m_tail, m_count, 1'b0});
    end
    state = 3'd3;
    next_head = 3'd4; next_tail = 3'd6; next_data_count = 4'd2;
    m_head = 3'd4; m_tail = 3'd6; m_count = 4'd2;
    cyc();
    checks++;
    if ({head, tail, data_count, wr_err, wr_ack} !== {m_head, m_tail, m_count, 2'b10}) begin
      errors++; $display("FAIL pass_wr_error actual=%h required=%h", {head, tail, data_count, wr_err, wr_ack}, {m_head, m_tail, m_count, 2'b10});
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp;
    test_reset();
    state = 3'd1; we = 1'b1; re = 1'b0; din = 32'h55;
    next_head = 3'd0; next_tail = 3'd1; next_data_count = 4'd1;
    cyc();
    checks++;
    if ({wr_ack, tail, data_count} !== {1'b1, 3'd1, 4'd1}) begin
      errors++; $display("FAIL mid_write actual=%h required=%h", {wr_ack, tail, data_count}, {1'b1, 3'd1, 4'd1});
    end
    state = 3'd2; we = 1'b0; re = 1'b1;
    next_head = 3'd1; next_tail = 3'd1; next_data_count = 4'd0;
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({head, tail, data_count, full, empty, wr_ack, wr_err, rd_ack, rd_err, dout} !== {3'd0, 3'd0, 4'd0, 2'b01, 4'b0000, 32'd0}) begin
      errors++; $display("FAIL mid_async_reset actual=%h required=%h", {head, tail, data_count, full, empty, wr_ack, wr_err, rd_ack, rd_err, dout}, {3'd0, 3'd0, 4'd0, 2'b01, 4'b0000, 32'd0});
    end
    cyc();
    reset = 1'b0;
    state = 3'd0; we = 1'b0; re = 1'b0;
    next_head = 3'd0; next_tail = 3'd1; next_data_count = 4'd1;
    m_tail = 3'd1; m_count = 4'd1;
    cyc();
    checks++;
    if ({head, tail, data_count} !== {m_head, m_tail, m_count}) begin
      errors++; $display("FAIL first_edge actual=%h required=%h", {head, tail, data_count}, {m_head, m_tail, m_count});
    end
    state = 3'd2; re = 1'b1;
    next_head = 3'd1; next_tail = 3'd1; next_data_count = 4'd0;
    exp_q.push_back(m_mem[m_head]);
    cyc();
    exp = exp_q.pop_front();
    checks++;
    if ({dout, rd_ack} !== {exp, 1'b1}) begin
      errors++; $display("FAIL read_after_reset actual=%h required=%h", {dout, rd_ack}, {exp, 1'b1});
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wr_full();
    test_drain();
    test_rd_empty();
    test_illegal();
    test_passthrough();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_in_store.md
FIFO_IN_STORE -- requirements
Module: fifo_in_store

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of din and dout.
REQ-002 The block SHALL have storage depth fixed at 8 entries addressed by 3-bit pointers; this is not parameterised.
REQ-003 The block SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL provide port reset, input, 1, asynchronous, active-high reset.
REQ-005 The block SHALL provide port state, input, 3, the FIFO control state code: IDLE=0, WRITE=1, READ=2, WR_ERROR=3, RD_ERROR=4.
REQ-006 The block SHALL provide port we, input, 1, the write enable from the address-calculation stage.
REQ-007 The block SHALL provide port re, input, 1, the read enable from the address-calculation stage.
REQ-008 The block SHALL provide ports next_head, next_tail, input, 3 each, and next_data_count, input, 4, the proposed pointer and count values.
REQ-009 The block SHALL provide port din, input, DATA_WIDTH, the write data.
REQ-010 The block SHALL provide port dout, output, DATA_WIDTH, the registered read data.
REQ-011 The block SHALL provide ports head, tail, output, 3 each, and data_count, output, 4, the registered pointers and count, fed back to the address-calculation stage.
REQ-012 The block SHALL provide ports full and empty, output, 1 each, the status flags.
REQ-013 The block SHALL provide ports wr_ack, wr_err, rd_ack and rd_err, output, 1 each, the registered handshake responses.

Function
REQ-014 The block SHALL compute full = (data_count == 8) and empty = (data_count == 0) combinationally from the registered data_count only.
REQ-015 The block SHALL treat a cycle as a legal write when state==WRITE, we=1, re=0 and full=0.
REQ-016 The block SHALL treat a cycle as a legal read when state==READ, re=1, we=0 and empty=0.
REQ-017 On a legal write, the block SHALL store mem[tail] <= din using the current (pre-update) tail, and load head/tail/data_count from next_head/next_tail/next_data_count.
REQ-018 On a legal read, the block SHALL load dout <= mem[head] using the current head, and load head/tail/data_count from the next_* inputs.
REQ-019 In a legal read, read data SHALL be visible on dout one clock after the READ edge; latency is 1 cycle.
REQ-020 In IDLE, WR_ERROR or RD_ERROR, the block SHALL load head/tail/data_count from next_* (pass-through hold) and perform no memory access.
REQ-021 When we=1 and full=1, or re=1 and empty=1 (guard violation), the block SHALL suppress the memory access and hold head, tail and data_count regardless of the next_* inputs.
REQ-022 When we=1 and re=1 in the same cycle, or state is 5 to 7, the block SHALL hold all registers, perform no memory access, and drive all four handshake outputs to 0 on the next edge.
REQ-023 When no legal read occurs, dout SHALL hold its previous value.
REQ-024 The block SHALL update handshake outputs every edge as single-cycle pulses:
- wr_ack <= legal write
- rd_ack <= legal read
- wr_err <= (state==WR_ERROR) or (we & full)
- rd_err <= (state==RD_ERROR) or (re & empty)
REQ-025 Pointer wrap (7 -> 0) SHALL be taken directly from the next_* inputs; the block performs no pointer arithmetic.
REQ-026 The block SHALL accept next_data_count only in the range 0..8; a value above 8 SHALL be treated as a guard violation and holding applies.

Reset
REQ-027 While reset=1, asynchronously and independent of clk, the block SHALL clear head=0, tail=0, data_count=0, dout=0, all handshake outputs=0, and all 8 memory entries=0.
REQ-028 After reset, empty SHALL read 1 and full SHALL read 0.
REQ-029 Reset asserted mid-write or mid-read SHALL abort the operation with no partial memory update.
REQ-030 The first edge after reset release SHALL be processed normally.

Verification
REQ-031 Reset then 8 legal writes of 0xA0..0xA7 -> tail wraps to 0, data_count=8, full=1, and wr_ack pulses on each write.
REQ-032 From full, 8 legal reads -> dout sequence 0xA0..0xA7 each 1 cycle after its READ, then empty=1 and head=0.
REQ-033 Write with full=1 (we=1, next_data_count=9) -> mem unchanged, data_count stays 8, wr_err=1 for one cycle.
REQ-034 Read with empty=1 (re=1) -> dout unchanged, head unchanged, rd_err=1 for one cycle.
REQ-035 Apply we=re=1, then state=6 -> all registers held and all four handshake outputs 0.
REQ-036 Assert reset between a WRITE edge and the following READ -> all outputs 0 immediately, and a read of entry 0 after release returns 0.
